nor_serial_logic_unit: RTL and testbench
========================================

Name: nor_serial_logic_unit

Overview:
- Parametrised, multi-cycle successor to the single-bit NOR-built gate modules.
- Applies one of eight two-operand logic functions to WIDTH-bit operands p and q, LANES bits per clock.
- Every function is realised from NOR primitives only, inside a per-lane slice.
- Start/busy/done handshake; result held until the next accepted start; sits as a small datapath unit behind a simple controller.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 1.
- LANES, 1, bits processed per clock; must divide WIDTH exactly. An illegal value is an elaboration error.
- N (localparam), WIDTH/LANES, RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- op  input  3  function select, captured with start
- p  input  WIDTH  operand p, captured with start
- q  input  WIDTH  operand q, captured with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result valid
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with done

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset, and is fixed as such.
- Reset: on any edge with reset=1:
  - state=IDLE, busy=0, done=0, result=0, zero=0.
  - Internal shift registers and lane counter are cleared.
  - Reset has priority over start and over any RUN in progress. An aborted operation never raises done.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: capture p, q and op into shift regs; counter=0; go to RUN; busy=1.
  - start=0: stay in IDLE.
- RUN:
  - Each edge: the slice consumes the LANES LSBs of the p/q shift regs.
  - The LANES result bits shift into the result shift reg from the MSB end, so the LSB lane ends at bit 0. The p/q regs shift right by LANES; counter increments.
  - On the edge where counter==N-1: load result and zero, go to DONE, done=1, busy=0.
  - start is ignored throughout RUN; no queuing.
- DONE:
  - done is high for exactly one cycle.
  - Next edge with start=1: capture new operands and go directly to RUN (back-to-back; done falls the same edge).
  - Otherwise go to IDLE.
- Latency: start captured at edge k → done high after edge k+N. Throughput is one operation per N+1 cycles.
- result/zero are stable from done until the edge after the next capture completes. The intermediate shift reg is not visible on result.
- Op encoding (all NOR-only in the slice):
  - 0: NOT p
  - 1: p AND q
  - 2: p OR q
  - 3: p AND NOT q
  - 4: p NAND q
  - 5: p NOR q
  - 6: p XOR q
  - 7: p XNOR q
- No arithmetic; the counter is ceil(log2(N)) bits wide, minimum 1. LANES==WIDTH gives N=1, i.e. one RUN cycle.

Optional Feature:
- Macro: NOR_LOGIC_UNIT_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit), the XOR-reduction of result.
  - Accumulated serially in RUN via NOR-built XOR; updated with done.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package nor_lu_pkg:
  - OP_NOT_P..OP_XNOR localparams (3-bit).
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module nor_lu_slice (combinational, parameter LANES):
  - Inputs: op, p lanes, q lanes.
  - Output: LANES result bits.
  - Built solely from nor primitives; reuses NOT/AND-via-NOR structure.
- The top holds the FSM, counter and shift registers.

Test Plan:
- WIDTH=8, LANES=1, op=3, p=0xF0, q=0xCC, start 1 cycle → busy for 8 cycles, done pulse after edge k+8, result=0x30, zero=0.
- op=6, p=0xA5, q=0xFF → result=0x5A. Immediately start op=5, p=0x0F, q=0xF0 in the DONE cycle → second done 8 cycles later, result=0x00, zero=1.
- Start op=1 with p=0xFF, q=0x3C; pulse start again in RUN cycle 3 with other operands → ignored, result=0x3C, exactly one done.
- Assert reset in RUN cycle 4 → next edge busy=0, done=0, result=0, state IDLE; no done afterward.
- WIDTH=8, LANES=4, op=0, p=0x81 → done after edge k+2, result=0x7E. Also LANES=8, op=2, p=0x12, q=0x40 → done after edge k+1, result=0x52.
- With NOR_LOGIC_UNIT_PARITY_EN: op=3, p=0xF0, q=0xCC → parity=0. op=1, p=0x07, q=0xFF → parity=1.

Source files
------------

// File: rtl/nor_lu_pkg.sv
// Shared definitions for the NOR-built serial logic unit: op codes, FSM states,
// and a NOR-composed XOR helper used by the optional parity accumulator.
package nor_lu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT_P = 3'd0;
  localparam logic [OP_W-1:0] OP_AND   = 3'd1;
  localparam logic [OP_W-1:0] OP_OR    = 3'd2;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // XOR composed of NOR terms: nor(nor(a,b), and(a,b)), and = nor(~a,~b)
  function automatic logic nor_xor(input logic a, input logic b);
    logic n_ab;
    logic a_and_b;
    n_ab    = ~(a | b);
    a_and_b = ~(~(a | a) | ~(b | b));
    return ~(n_ab | a_and_b);
  endfunction

endpackage

// File: rtl/nor_lu_slice.sv
// Combinational per-lane slice: evaluates all eight functions from NOR gates
// and selects one with a NOR-built one-hot decode and AND-OR mux.
module nor_lu_slice
  import nor_lu_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic [OP_W-1:0]  op,
  input  logic [LANES-1:0] p,
  input  logic [LANES-1:0] q,
  output logic [LANES-1:0] r
);

  wire [OP_W-1:0]  op_n;
  wire [7:0]       dec;
  wire [7:0]       dec_n;
  wire [LANES-1:0] r_w;

  // Inverted op bits feed the decoder literals
  for (genvar j = 0; j < int'(OP_W); j++) begin : g_opn
    nor u_opn (op_n[j], op[j], op[j]);
  end

  // One-hot op decode: dec[i] high when every literal that must be 0 is 0
  for (genvar i = 0; i < 8; i++) begin : g_dec
    localparam logic [OP_W-1:0] IB = 3'(i);
    wire [OP_W-1:0] lit;
    for (genvar j = 0; j < int'(OP_W); j++) begin : g_lit
      if (IB[j]) begin : g_inv
        assign lit[j] = op_n[j];
      end else begin : g_pos
        assign lit[j] = op[j];
      end
    end
    nor u_dec  (dec[i], lit[0], lit[1], lit[2]);
    nor u_decn (dec_n[i], dec[i], dec[i]);
  end

  // Per-lane function network and NOR-based select
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    wire np, nq, nor_pq, or_pq, and_pq, nand_pq, andn_pq, xor_pq, xnor_pq;
    wire [7:0] f;
    wire [7:0] nf;
    wire [7:0] term;
    wire       rn;

    nor u_np   (np,      p[l],   p[l]);
    nor u_nq   (nq,      q[l],   q[l]);
    nor u_nor  (nor_pq,  p[l],   q[l]);
    nor u_or   (or_pq,   nor_pq, nor_pq);
    nor u_and  (and_pq,  np,     nq);
    nor u_nand (nand_pq, and_pq, and_pq);
    nor u_andn (andn_pq, np,     q[l]);
    nor u_xor  (xor_pq,  nor_pq, and_pq);
    nor u_xnor (xnor_pq, xor_pq, xor_pq);

    assign f = {xnor_pq, xor_pq, nor_pq, nand_pq, andn_pq, or_pq, and_pq, np};

    for (genvar k = 0; k < 8; k++) begin : g_term
      nor u_nf   (nf[k],   f[k],  f[k]);
      nor u_term (term[k], nf[k], dec_n[k]);
    end

    nor u_rn  (rn, term[0], term[1], term[2], term[3],
                   term[4], term[5], term[6], term[7]);
    nor u_res (r_w[l], rn, rn);
  end

  assign r = r_w;

endmodule

// File: rtl/nor_serial_logic_unit.sv
// Multi-cycle logic unit: applies a NOR-built two-operand function to WIDTH-bit
// operands, LANES bits per clock, behind a start/busy/done handshake.
// Optional build macro: NOR_LOGIC_UNIT_PARITY_EN adds a serially accumulated
// parity output alongside result.
module nor_serial_logic_unit
  import nor_lu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef NOR_LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int unsigned N  = WIDTH / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
    $error("nor_serial_logic_unit: LANES must be >= 1 and divide WIDTH exactly");
  end

  state_t           state;
  logic [WIDTH-1:0] p_sh;
  logic [WIDTH-1:0] q_sh;
  logic [OP_W-1:0]  op_r;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] lane_r;
  logic [WIDTH-1:0] res_next_c;

  nor_lu_slice #(.LANES(LANES)) u_slice (
    .op (op_r),
    .p  (p_sh[LANES-1:0]),
    .q  (q_sh[LANES-1:0]),
    .r  (lane_r)
  );

  if (N > 1) begin : g_res_sh
    logic [WIDTH-LANES-1:0] res_sh;

    assign res_next_c = {lane_r, res_sh};

    // Partial result collects lanes from the MSB end; never exposed on result
    always_ff @(posedge clk) begin
      if (reset) begin
        res_sh <= '0;
      end else if (state == RUN) begin
        res_sh <= res_next_c[WIDTH-1:LANES];
      end
    end
  end else begin : g_res_direct
    assign res_next_c = lane_r;
  end

  // Control FSM, operand shifters, lane counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      p_sh   <= '0;
      q_sh   <= '0;
      op_r   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            p_sh  <= p;
            q_sh  <= q;
            op_r  <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p_sh <= p_sh >> LANES;
          q_sh <= q_sh >> LANES;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            result <= res_next_c;
            zero   <= (res_next_c == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NOR_LOGIC_UNIT_PARITY_EN
  logic par_acc;
  logic lane_par_c;
  logic par_next_c;

  // Fold this cycle's lane bits into the running parity via NOR-built XOR
  always_comb begin
    lane_par_c = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_par_c = nor_xor(lane_par_c, lane_r[i]);
    end
    par_next_c = nor_xor(par_acc, lane_par_c);
  end

  // Running parity clears outside RUN; published together with done
  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc <= 1'b0;
      parity  <= 1'b0;
    end else if (state == RUN) begin
      par_acc <= par_next_c;
      if (cnt == CW'(N - 1)) begin
        parity <= par_next_c;
      end
    end else begin
      par_acc <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nor_serial_logic_unit.sv
// Self-checking bench for nor_serial_logic_unit: three instances (LANES 1, 4, 8)
// driven with directed and random operations, checked against a word-level model.
module tb_nor_serial_logic_unit;
  import nor_lu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [7:0] p;
  logic [7:0] q;
  logic       start_a, start_b, start_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] result_a, result_b, result_c;
  logic       zero_a, zero_b, zero_c;
`ifdef NOR_LOGIC_UNIT_PARITY_EN
  logic       parity_a, parity_b, parity_c;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nor_serial_logic_unit #(.WIDTH(8), .LANES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op), .p(p), .q(q),
    .busy(busy_a), .done(done_a), .result(result_a), .zero(zero_a)
`ifdef NOR_LOGIC_UNIT_PARITY_EN
    , .parity(parity_a)
`endif
  );

  nor_serial_logic_unit #(.WIDTH(8), .LANES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op), .p(p), .q(q),
    .busy(busy_b), .done(done_b), .result(result_b), .zero(zero_b)
`ifdef NOR_LOGIC_UNIT_PARITY_EN
    , .parity(parity_b)
`endif
  );

  nor_serial_logic_unit #(.WIDTH(8), .LANES(8)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .op(op), .p(p), .q(q),
    .busy(busy_c), .done(done_c), .result(result_c), .zero(zero_c)
`ifdef NOR_LOGIC_UNIT_PARITY_EN
    , .parity(parity_c)
`endif
  );

  // Word-level reference for the eight functions
  function automatic logic [7:0] ref_fn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      OP_NOT_P: return ~a;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ANDN:  return a & ~b;
      OP_NAND:  return ~(a & b);
      OP_NOR:   return ~(a | b);
      OP_XOR:   return a ^ b;
      default:  return ~(a ^ b);
    endcase
  endfunction

  function automatic int ref_lat(input int w);
    case (w)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic f_busy(input int w);
    case (w) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction

  function automatic logic f_done(input int w);
    case (w) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction

  function automatic logic [7:0] f_result(input int w);
    case (w) 0: return result_a; 1: return result_b; default: return result_c; endcase
  endfunction

  function automatic logic f_zero(input int w);
    case (w) 0: return zero_a; 1: return zero_b; default: return zero_c; endcase
  endfunction

  function automatic logic f_parity(input int w);
`ifdef NOR_LOGIC_UNIT_PARITY_EN
    case (w) 0: return parity_a; 1: return parity_b; default: return parity_c; endcase
`else
    return (w < 0);
`endif
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Issue one operation and observe it until done or the cycle budget expires
  task automatic run_op(input int w, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt, output int unstable,
                        output logic b0, output logic d0,
                        output logic [7:0] res, output logic z, output logic par);
    logic [7:0] prev;
    @(negedge clk);
    op = o; p = a; q = b;
    prev = f_result(w);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    b0 = f_busy(w);
    d0 = f_done(w);
    lat = -1; busy_cnt = 0; unstable = 0;
    for (int i = 1; i <= 40; i++) begin
      if (f_busy(w)) busy_cnt++;
      if (f_result(w) !== prev) unstable++;
      @(posedge clk); #1;
      if (f_done(w)) begin
        lat = i;
        break;
      end
    end
    res = f_result(w);
    z   = f_zero(w);
    par = f_parity(w);
  endtask

  task automatic test_reset();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    op = '0; p = '0; q = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      n_cmp++; if (f_busy(w) !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b expected 0", w, f_busy(w)); end
      n_cmp++; if (f_done(w) !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b expected 0", w, f_done(w)); end
      n_cmp++; if (f_result(w) !== 8'h00) begin n_bad++; $display("FAIL reset_result[%0d]: got %h expected 00", w, f_result(w)); end
      n_cmp++; if (f_zero(w) !== 1'b0) begin n_bad++; $display("FAIL reset_zero[%0d]: got %b expected 0", w, f_zero(w)); end
`ifdef NOR_LOGIC_UNIT_PARITY_EN
      n_cmp++; if (f_parity(w) !== 1'b0) begin n_bad++; $display("FAIL reset_parity[%0d]: got %b expected 0", w, f_parity(w)); end
`endif
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_andn_serial();
    int lat, bc, un; logic b0, d0, z, par; logic [7:0] res;
    run_op(0, 3'd3, 8'hF0, 8'hCC, lat, bc, un, b0, d0, res, z, par);
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL andn_busy_after_start: got %b expected 1", b0); end
    n_cmp++; if (bc != 8) begin n_bad++; $display("FAIL andn_busy_cycles: got %0d expected 8", bc); end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL andn_latency: got %0d expected 8", lat); end
    n_cmp++; if (res !== 8'h30) begin n_bad++; $display("FAIL andn_result: got %h expected 30", res); end
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL andn_zero: got %b expected 0", z); end
    n_cmp++; if (un != 0) begin n_bad++; $display("FAIL andn_result_stable: got %0d changes expected 0", un); end
`ifdef NOR_LOGIC_UNIT_PARITY_EN
    n_cmp++; if (par !== 1'b0) begin n_bad++; $display("FAIL andn_parity: got %b expected 0", par); end
`endif
    @(posedge clk); #1;
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL andn_done_one_cycle: got %b expected 0", done_a); end
    n_cmp++; if (result_a !== 8'h30) begin n_bad++; $display("FAIL andn_result_held: got %h expected 30", result_a); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, un; logic b0, d0, z, par; logic [7:0] res;
    run_op(0, 3'd6, 8'hA5, 8'hFF, lat, bc, un, b0, d0, res, z, par);
    n_cmp++; if (res !== 8'h5A) begin n_bad++; $display("FAIL b2b_first_result: got %h expected 5a", res); end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 8", lat); end
    run_op(0, 3'd5, 8'h0F, 8'hF0, lat, bc, un, b0, d0, res, z, par);
    n_cmp++; if (d0 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_falls: got %b expected 0", d0); end
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_rises: got %b expected 1", b0); end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 8", lat); end
    n_cmp++; if (res !== 8'h00) begin n_bad++; $display("FAIL b2b_second_result: got %h expected 00", res); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL b2b_second_zero: got %b expected 1", z); end
    n_cmp++; if (un != 0) begin n_bad++; $display("FAIL b2b_result_stable: got %0d changes expected 0", un); end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int first = -1;
    logic [7:0] res = 8'hxx;
    repeat (2) @(posedge clk);
    @(negedge clk);
    op = 3'd1; p = 8'hFF; q = 8'h3C; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_a = (i == 3);
      if (i == 3) begin op = 3'd2; p = 8'h11; q = 8'h22; end
      @(posedge clk); #1;
      if (done_a) begin
        dones++;
        if (first < 0) begin first = i; res = result_a; end
      end
    end
    start_a = 1'b0;
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    n_cmp++; if (first != 8) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 8", first); end
    n_cmp++; if (res !== 8'h3C) begin n_bad++; $display("FAIL ignore_result: got %h expected 3c", res); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    @(negedge clk);
    op = 3'd7; p = 8'h5A; q = 8'h3C; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b expected 0", done_a); end
    n_cmp++; if (result_a !== 8'h00) begin n_bad++; $display("FAIL abort_result: got %h expected 00", result_a); end
    n_cmp++; if (zero_a !== 1'b0) begin n_bad++; $display("FAIL abort_zero: got %b expected 0", zero_a); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dones); end
  endtask

  task automatic test_lanes();
    int lat, bc, un; logic b0, d0, z, par; logic [7:0] res;
    run_op(1, 3'd0, 8'h81, 8'h00, lat, bc, un, b0, d0, res, z, par);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL lanes4_latency: got %0d expected 2", lat); end
    n_cmp++; if (bc != 2) begin n_bad++; $display("FAIL lanes4_busy_cycles: got %0d expected 2", bc); end
    n_cmp++; if (res !== 8'h7E) begin n_bad++; $display("FAIL lanes4_result: got %h expected 7e", res); end
    run_op(2, 3'd2, 8'h12, 8'h40, lat, bc, un, b0, d0, res, z, par);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL lanes8_latency: got %0d expected 1", lat); end
    n_cmp++; if (res !== 8'h52) begin n_bad++; $display("FAIL lanes8_result: got %h expected 52", res); end
`ifdef NOR_LOGIC_UNIT_PARITY_EN
    run_op(0, 3'd1, 8'h07, 8'hFF, lat, bc, un, b0, d0, res, z, par);
    n_cmp++; if (par !== 1'b1) begin n_bad++; $display("FAIL parity_and: got %b expected 1", par); end
`endif
  endtask

  task automatic test_random();
    int lat, bc, un; logic b0, d0, z, par; logic [7:0] res, exp_r;
    for (int n = 0; n < 60; n++) begin
      int w;
      logic [2:0] o;
      logic [7:0] a, b;
      w = int'($urandom_range(0, 2));
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = (n % 8 == 0) ? a : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      exp_r = ref_fn(o, a, b);
      run_op(w, o, a, b, lat, bc, un, b0, d0, res, z, par);
      n_cmp++; if (res !== exp_r) begin n_bad++; $display("FAIL rand_result[%0d] dut%0d op%0d p=%h q=%h: got %h expected %h", n, w, o, a, b, res, exp_r); end
      n_cmp++; if (z !== (exp_r == 8'h00)) begin n_bad++; $display("FAIL rand_zero[%0d]: got %b expected %b", n, z, exp_r == 8'h00); end
      n_cmp++; if (lat != ref_lat(w)) begin n_bad++; $display("FAIL rand_latency[%0d] dut%0d: got %0d expected %0d", n, w, lat, ref_lat(w)); end
      n_cmp++; if (un != 0) begin n_bad++; $display("FAIL rand_result_stable[%0d]: got %0d changes expected 0", n, un); end
`ifdef NOR_LOGIC_UNIT_PARITY_EN
      n_cmp++; if (par !== ^exp_r) begin n_bad++; $display("FAIL rand_parity[%0d]: got %b expected %b", n, par, ^exp_r); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_andn_serial();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_lanes();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
